// File: rtl/fpu_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin FP-unit arbiter.
package fpu_arb_pkg;

    // One operation at a time: wait for a request, move both operands, then the result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_Z = 2'd2
    } arb_state_t;

    // IEEE-754 single precision operand/result width.
    localparam int FP_DW = 32;

endpackage

// File: rtl/fpu_rr_arbiter_rr_pick.sv
// Round-robin picker: first requesting index after i_ptr, wrapping modulo NREQ.
// Purely combinational; the caller owns the pointer register.
module rr_pick
    import fpu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic            o_found,
    output logic [PW-1:0]   o_idx
);

    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0] w_cand;

    // Walk ptr+1, ptr+2, ... and keep the first hit; i_ptr itself is visited last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = i_ptr;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = (w_cand == LAST) ? '0 : w_cand + 1'b1;
            if (i_req[w_cand] && !o_found) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Shares a single stb/ack FP unit among NREQ requesters. A grant covers one
// whole operation (A and B operand transfers, then the result transfer);
// requesters are served round-robin and the data path is a plain mux/demux.
module fpu_rr_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = FP_DW,
    parameter int CNT_W = 16
) (
    input  logic               iClk,
    input  logic               iRstn,
    input  logic [NREQ*DW-1:0] rq_a,
    input  logic [NREQ*DW-1:0] rq_b,
    input  logic [NREQ-1:0]    rq_a_stb,
    input  logic [NREQ-1:0]    rq_b_stb,
    output logic [NREQ-1:0]    rq_a_ack,
    output logic [NREQ-1:0]    rq_b_ack,
    output logic [DW-1:0]      rq_z,
    output logic [NREQ-1:0]    rq_z_stb,
    input  logic [NREQ-1:0]    rq_z_ack,
    output logic [DW-1:0]      fu_a,
    output logic [DW-1:0]      fu_b,
    output logic               fu_a_stb,
    output logic               fu_b_stb,
    input  logic               fu_a_ack,
    input  logic               fu_b_ack,
    input  logic [DW-1:0]      fu_z,
    input  logic               fu_z_stb,
    output logic               fu_z_ack,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    localparam int              PW       = $clog2(NREQ);
    localparam logic [PW-1:0]   PTR_LAST = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    // Registered FSM state. r_ptr doubles as the granted index while busy.
    arb_state_t       r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [PW-1:0]    r_ptr;
    logic             r_a_done;
    logic             r_b_done;
    logic [CNT_W-1:0] r_op_count;

    logic [DW-1:0]    w_a_arr [NREQ];
    logic [DW-1:0]    w_b_arr [NREQ];
    logic [NREQ-1:0]  w_req;
    logic             w_found;
    logic [PW-1:0]    w_idx;
    logic [NREQ-1:0]  w_new_gnt;
    logic             w_send;
    logic             w_waitz;
    logic             w_a_xfer;
    logic             w_b_xfer;
    logic             w_a_fin;
    logic             w_b_fin;
    logic             w_z_xfer;

    // Unpack the flat operand buses into per-requester words.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign w_a_arr[gi] = rq_a[gi*DW +: DW];
        assign w_b_arr[gi] = rq_b[gi*DW +: DW];
    end

    // A requester is only eligible once it presents both operands.
    assign w_req = rq_a_stb & rq_b_stb;

    // One picker serves both IDLE arbitration and the same-cycle re-arbitration
    // at result handoff; in both cases r_ptr is the last winner.
    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_new_gnt = ONE << w_idx;
    assign w_send    = (r_state == SEND);
    assign w_waitz   = (r_state == WAIT_Z);

    // Operand path: granted requester's data straight through; each strobe is
    // masked once its operand has been taken so the unit never sees it twice.
    assign fu_a     = w_a_arr[r_ptr];
    assign fu_b     = w_b_arr[r_ptr];
    assign fu_a_stb = w_send & rq_a_stb[r_ptr] & ~r_a_done;
    assign fu_b_stb = w_send & rq_b_stb[r_ptr] & ~r_b_done;
    assign rq_a_ack = (w_send & fu_a_ack) ? r_gnt : '0;
    assign rq_b_ack = (w_send & fu_b_ack) ? r_gnt : '0;

    assign w_a_xfer = fu_a_stb & fu_a_ack;
    assign w_b_xfer = fu_b_stb & fu_b_ack;
    assign w_a_fin  = r_a_done | w_a_xfer;
    assign w_b_fin  = r_b_done | w_b_xfer;

    // Result path: data broadcast, valid only to the granted requester.
    assign rq_z     = fu_z;
    assign rq_z_stb = (w_waitz & fu_z_stb) ? r_gnt : '0;
    assign fu_z_ack = w_waitz & (|(rq_z_ack & r_gnt));
    assign w_z_xfer = fu_z_stb & fu_z_ack;

    assign gnt      = r_gnt;
    assign busy     = (r_state != IDLE);
    assign op_count = r_op_count;

    // Arbitration FSM, operand-done flags and completed-operation counter.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_ptr      <= PTR_LAST;
            r_a_done   <= 1'b0;
            r_b_done   <= 1'b0;
            r_op_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_new_gnt;
                        r_ptr    <= w_idx;
                        r_a_done <= 1'b0;
                        r_b_done <= 1'b0;
                        r_state  <= SEND;
                    end
                end
                SEND: begin
                    r_a_done <= w_a_fin;
                    r_b_done <= w_b_fin;
                    if (w_a_fin && w_b_fin) begin
                        r_state <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (w_z_xfer) begin
                        r_op_count <= r_op_count + 1'b1;
                        r_a_done   <= 1'b0;
                        r_b_done   <= 1'b0;
                        // Hand straight to the next requester to avoid an idle cycle.
                        if (w_found) begin
                            r_gnt   <= w_new_gnt;
                            r_ptr   <= w_idx;
                            r_state <= SEND;
                        end else begin
                            r_gnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Directed bench for fpu_rr_arbiter: requester models plus a 4-cycle FP unit
// model with a fixed table of hand-computed single-precision products.
module tb_fpu_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int CNT_W = 4;
    localparam int LAT   = 4;

    // Per-requester operands and their products (2*3, 1*5, 4*4, 0.5*3).
    localparam logic [DW-1:0] OPA  [NREQ] = '{32'h40000000, 32'h3F800000, 32'h40800000, 32'h3F000000};
    localparam logic [DW-1:0] OPB  [NREQ] = '{32'h40400000, 32'h40A00000, 32'h40800000, 32'h40400000};
    localparam logic [DW-1:0] EXPZ [NREQ] = '{32'h40C00000, 32'h40A00000, 32'h41800000, 32'h3FC00000};

    logic               iClk = 1'b0;
    logic               iRstn;
    logic [NREQ*DW-1:0] rq_a, rq_b;
    logic [NREQ-1:0]    rq_a_stb, rq_b_stb, rq_a_ack, rq_b_ack;
    logic [DW-1:0]      rq_z;
    logic [NREQ-1:0]    rq_z_stb, rq_z_ack;
    logic [DW-1:0]      fu_a, fu_b, fu_z;
    logic               fu_a_stb, fu_b_stb, fu_a_ack, fu_b_ack, fu_z_stb, fu_z_ack;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [CNT_W-1:0]   op_count;

    fpu_rr_arbiter #(.NREQ(NREQ), .DW(DW), .CNT_W(CNT_W)) dut (
        .iClk(iClk), .iRstn(iRstn),
        .rq_a(rq_a), .rq_b(rq_b), .rq_a_stb(rq_a_stb), .rq_b_stb(rq_b_stb),
        .rq_a_ack(rq_a_ack), .rq_b_ack(rq_b_ack),
        .rq_z(rq_z), .rq_z_stb(rq_z_stb), .rq_z_ack(rq_z_ack),
        .fu_a(fu_a), .fu_b(fu_b), .fu_a_stb(fu_a_stb), .fu_b_stb(fu_b_stb),
        .fu_a_ack(fu_a_ack), .fu_b_ack(fu_b_ack),
        .fu_z(fu_z), .fu_z_stb(fu_z_stb), .fu_z_ack(fu_z_ack),
        .gnt(gnt), .busy(busy), .op_count(op_count)
    );

    always #5 iClk = ~iClk;

    int n_chk = 0;
    int n_pass = 0;

    // Environment state (requesters + FP unit model).
    int              want [NREQ];
    bit              active [NREQ], a_pend [NREQ], b_pend [NREQ], zack_en [NREQ];
    logic [DW-1:0]   res_last [NREQ];
    int              done_total = 0;
    bit              fa_en, fb_en, have_a, have_b, have_res, computing;
    int              lat;
    logic [DW-1:0]   la, lb, res, ca, cb, zval;
    bit              ax, bx, zx;
    logic [NREQ-1:0] rax, rbx, rzx, gprev;
    logic [NREQ-1:0] glog [$];

    function automatic logic [DW-1:0] fu_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        case ({a, b})
            64'h40000000_40400000: return 32'h40C00000;
            64'h3F800000_40A00000: return 32'h40A00000;
            64'h40800000_40800000: return 32'h41800000;
            64'h3F000000_40400000: return 32'h3FC00000;
            64'h3FC00000_40800000: return 32'h40C00000;
            default:               return 32'hFFFFFFFF;
        endcase
    endfunction

    task automatic clear_env();
        for (int i = 0; i < NREQ; i++) begin
            want[i] = 0; active[i] = 0; a_pend[i] = 0; b_pend[i] = 0;
        end
        have_a = 0; have_b = 0; have_res = 0; computing = 0; lat = 0; res = '0;
        rq_a_stb = '0; rq_b_stb = '0; rq_z_ack = '0;
        fu_a_ack = 0; fu_b_ack = 0; fu_z_stb = 0; fu_z = '0; gprev = '0;
    endtask

    // Drive on negedge, sample 1 time unit later, update models at posedge.
    initial begin : env
        clear_env();
        fa_en = 1; fb_en = 1;
        for (int i = 0; i < NREQ; i++) begin
            zack_en[i] = 1; res_last[i] = '0;
            rq_a[i*DW +: DW] = OPA[i];
            rq_b[i*DW +: DW] = OPB[i];
        end
        forever begin
            @(negedge iClk);
            if (!iRstn) clear_env();
            for (int i = 0; i < NREQ; i++) begin
                if (want[i] > 0 && !active[i]) begin
                    active[i] = 1; a_pend[i] = 1; b_pend[i] = 1;
                end
                rq_a_stb[i] = a_pend[i];
                rq_b_stb[i] = b_pend[i];
                rq_z_ack[i] = active[i] && zack_en[i];
            end
            fu_a_ack = fa_en && !have_a;
            fu_b_ack = fb_en && !have_b;
            fu_z_stb = have_res;
            fu_z     = res;
            #1;
            ax = fu_a_stb && fu_a_ack; bx = fu_b_stb && fu_b_ack; zx = fu_z_stb && fu_z_ack;
            ca = fu_a; cb = fu_b;
            rax = rq_a_stb & rq_a_ack; rbx = rq_b_stb & rq_b_ack; rzx = rq_z_stb & rq_z_ack;
            zval = rq_z;
            if (gnt != '0 && gnt != gprev) glog.push_back(gnt);
            gprev = gnt;
            @(posedge iClk);
            if (iRstn) begin
                if (ax) begin have_a = 1; la = ca; end
                if (bx) begin have_b = 1; lb = cb; end
                if (zx) have_res = 0;
                if (computing) begin
                    lat--;
                    if (lat == 0) begin
                        have_res = 1; res = fu_mul(la, lb); computing = 0; have_a = 0; have_b = 0;
                    end
                end else if (have_a && have_b && !have_res) begin
                    computing = 1; lat = LAT;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (rax[i]) a_pend[i] = 0;
                    if (rbx[i]) b_pend[i] = 0;
                    if (rzx[i]) begin
                        res_last[i] = zval; active[i] = 0; want[i]--; done_total++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge iClk);
        #2;
    endtask

    task automatic do_reset();
        iRstn = 1'b0;
        tick(); tick();
        iRstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        iRstn = 1'b0;
        tick(); tick();
        n_chk++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (op_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", op_count); else n_pass++;
        n_chk++; if ({fu_a_stb, fu_b_stb, fu_z_ack, rq_a_ack, rq_b_ack, rq_z_stb} !== '0)
            $display("FAIL reset_hs: got %b want all 0", {fu_a_stb, fu_b_stb, fu_z_ack, rq_a_ack, rq_b_ack, rq_z_stb});
        else n_pass++;
        iRstn = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        bit ok = 0;
        want[0] = 1;
        tick();
        n_chk++; if (gnt !== 4'b0000) $display("FAIL single_gnt_early: got %b want 0000", gnt); else n_pass++;
        tick();
        n_chk++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rq_z_stb != '0) begin ok = 1; break; end
        end
        n_chk++; if (!ok) $display("FAIL single_timeout: no result in 40 cycles"); else n_pass++;
        n_chk++; if (rq_z_stb !== 4'b0001) $display("FAIL single_zstb: got %b want 0001", rq_z_stb); else n_pass++;
        n_chk++; if (rq_z !== 32'h40C00000) $display("FAIL single_z: got %h want 40c00000", rq_z); else n_pass++;
        tick();
        n_chk++; if (op_count !== 4'd1) $display("FAIL single_count: got %0d want 1", op_count); else n_pass++;
        n_chk++; if ({busy, gnt} !== 5'b0) $display("FAIL single_idle: got busy=%b gnt=%b want 0/0000", busy, gnt); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int base, idle = 0;
        bit seen = 0, ok = 0;
        do_reset();
        glog.delete();
        base = done_total;
        want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (done_total >= base + 5) begin ok = 1; break; end
            if (busy) seen = 1;
            else if (seen) idle++;
        end
        n_chk++; if (!ok) $display("FAIL rr_timeout: %0d of 5 ops done", done_total - base); else n_pass++;
        n_chk++; if (idle != 0) $display("FAIL rr_idle: got %0d idle cycles want 0", idle); else n_pass++;
        n_chk++; if (glog.size() != 5) $display("FAIL rr_ngrants: got %0d want 5", glog.size()); else n_pass++;
        for (int k = 0; k < 5 && k < glog.size(); k++) begin
            n_chk++; if (glog[k] !== exp_g[k]) $display("FAIL rr_order%0d: got %b want %b", k, glog[k], exp_g[k]); else n_pass++;
        end
        for (int i = 0; i < NREQ; i++) begin
            n_chk++; if (res_last[i] !== EXPZ[i]) $display("FAIL rr_result%0d: got %h want %h", i, res_last[i], EXPZ[i]); else n_pass++;
        end
        n_chk++; if (op_count !== 4'd5) $display("FAIL rr_count: got %0d want 5", op_count); else n_pass++;
    endtask

    task automatic test_split_handshake();
        bit ok = 0, other_bad = 0;
        int base = done_total;
        fa_en = 0; fb_en = 0;
        want[2] = 1; want[3] = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnt != '0) begin ok = 1; break; end
        end
        n_chk++; if (!ok) $display("FAIL split_grant_timeout: no grant"); else n_pass++;
        n_chk++; if (gnt !== 4'b0100) $display("FAIL split_gnt: got %b want 0100", gnt); else n_pass++;
        fa_en = 1;
        tick();  // cycle k: A accepted
        if (((rq_a_ack | rq_b_ack) & 4'b1011) != '0) other_bad = 1;
        n_chk++; if ({fu_a_stb, fu_b_stb} !== 2'b11) $display("FAIL split_k_stb: got %b want 11", {fu_a_stb, fu_b_stb}); else n_pass++;
        n_chk++; if (rq_a_ack !== 4'b0100) $display("FAIL split_k_aack: got %b want 0100", rq_a_ack); else n_pass++;
        fa_en = 0;
        for (int c = 1; c <= 2; c++) begin
            tick();
            if (((rq_a_ack | rq_b_ack) & 4'b1011) != '0) other_bad = 1;
            n_chk++; if ({fu_a_stb, fu_b_stb} !== 2'b01) $display("FAIL split_k%0d_stb: got %b want 01", c, {fu_a_stb, fu_b_stb}); else n_pass++;
        end
        fb_en = 1;
        tick();  // cycle k+3: B accepted
        if (((rq_a_ack | rq_b_ack) & 4'b1011) != '0) other_bad = 1;
        n_chk++; if (rq_b_ack !== 4'b0100) $display("FAIL split_k3_back: got %b want 0100", rq_b_ack); else n_pass++;
        tick();  // now waiting for the result
        if (((rq_a_ack | rq_b_ack) & 4'b1011) != '0) other_bad = 1;
        n_chk++; if ({fu_a_stb, fu_b_stb, busy} !== 3'b001) $display("FAIL split_waitz: got stb=%b busy=%b want 00/1", {fu_a_stb, fu_b_stb}, busy); else n_pass++;
        n_chk++; if (gnt !== 4'b0100) $display("FAIL split_hold_gnt: got %b want 0100", gnt); else n_pass++;
        n_chk++; if (other_bad) $display("FAIL split_other_ack: got nonzero want 0"); else n_pass++;
        fa_en = 1;
        ok = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done_total >= base + 2) begin ok = 1; break; end
        end
        n_chk++; if (!ok) $display("FAIL split_done_timeout: %0d of 2 ops", done_total - base); else n_pass++;
        n_chk++; if (res_last[2] !== EXPZ[2]) $display("FAIL split_res2: got %h want %h", res_last[2], EXPZ[2]); else n_pass++;
        n_chk++; if (res_last[3] !== EXPZ[3]) $display("FAIL split_res3: got %h want %h", res_last[3], EXPZ[3]); else n_pass++;
        n_chk++; if (op_count !== 4'd7) $display("FAIL split_count: got %0d want 7", op_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok = 0;
        int base = done_total;
        zack_en[1] = 0;
        want[1] = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnt == 4'b0010) begin ok = 1; break; end
        end
        n_chk++; if (!ok) $display("FAIL bp_grant_timeout: got %b want 0010", gnt); else n_pass++;
        want[0] = 1;
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rq_z_stb[1]) begin ok = 1; break; end
        end
        n_chk++; if (!ok) $display("FAIL bp_result_timeout: no rq_z_stb[1]"); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            n_chk++; if ({fu_z_stb, fu_z_ack} !== 2'b10) $display("FAIL bp_hold%0d: got stb/ack=%b want 10", c, {fu_z_stb, fu_z_ack}); else n_pass++;
            n_chk++; if (gnt !== 4'b0010) $display("FAIL bp_gnt%0d: got %b want 0010", c, gnt); else n_pass++;
            tick();
        end
        zack_en[1] = 1;
        tick();
        n_chk++; if (fu_z_ack !== 1'b1) $display("FAIL bp_zack: got %b want 1", fu_z_ack); else n_pass++;
        n_chk++; if (rq_z !== EXPZ[1]) $display("FAIL bp_z: got %h want %h", rq_z, EXPZ[1]); else n_pass++;
        tick();
        n_chk++; if ({busy, gnt} !== 5'b10001) $display("FAIL bp_next_gnt: got busy=%b gnt=%b want 1/0001", busy, gnt); else n_pass++;
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_total >= base + 2) begin ok = 1; break; end
        end
        n_chk++; if (!ok) $display("FAIL bp_done_timeout: %0d of 2 ops", done_total - base); else n_pass++;
        n_chk++; if (res_last[0] !== EXPZ[0]) $display("FAIL bp_res0: got %h want %h", res_last[0], EXPZ[0]); else n_pass++;
        n_chk++; if (op_count !== 4'd9) $display("FAIL bp_count: got %0d want 9", op_count); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        bit ok = 0;
        int base;
        zack_en[2] = 0;
        want[2] = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rq_z_stb[2]) begin ok = 1; break; end
        end
        n_chk++; if (!ok) $display("FAIL rmid_waitz_timeout: never reached result phase"); else n_pass++;
        #1 iRstn = 1'b0;
        #1;
        n_chk++; if ({fu_a_stb, fu_b_stb, fu_z_ack, rq_a_ack, rq_b_ack, rq_z_stb} !== '0)
            $display("FAIL rmid_hs: got %b want all 0", {fu_a_stb, fu_b_stb, fu_z_ack, rq_a_ack, rq_b_ack, rq_z_stb});
        else n_pass++;
        n_chk++; if ({busy, gnt} !== 5'b0) $display("FAIL rmid_gnt: got busy=%b gnt=%b want 0/0000", busy, gnt); else n_pass++;
        n_chk++; if (op_count !== 4'd0) $display("FAIL rmid_count: got %0d want 0", op_count); else n_pass++;
        tick(); tick();
        zack_en[2] = 1;
        iRstn = 1'b1;
        base = done_total;
        want[3] = 1; want[0] = 1;
        tick();
        tick();
        n_chk++; if (gnt !== 4'b0001) $display("FAIL rmid_first_gnt: got %b want 0001", gnt); else n_pass++;
        ok = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done_total >= base + 2) begin ok = 1; break; end
        end
        n_chk++; if (!ok) $display("FAIL rmid_done_timeout: %0d of 2 ops", done_total - base); else n_pass++;
        n_chk++; if (op_count !== 4'd2) $display("FAIL rmid_count2: got %0d want 2", op_count); else n_pass++;
    endtask

    task automatic test_counter_wrap();
        bit ok = 0;
        int base;
        do_reset();
        base = done_total;
        want[0] = 5; want[1] = 4; want[2] = 4; want[3] = 4;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (done_total >= base + 17) begin ok = 1; break; end
        end
        n_chk++; if (!ok) $display("FAIL wrap_timeout: %0d of 17 ops", done_total - base); else n_pass++;
        n_chk++; if (op_count !== 4'd1) $display("FAIL wrap_count: got %0d want 1", op_count); else n_pass++;
        n_chk++; if (res_last[3] !== EXPZ[3]) $display("FAIL wrap_res3: got %h want %h", res_last[3], EXPZ[3]); else n_pass++;
    endtask

    initial begin : main
        test_reset();
        test_single_op();
        test_round_robin();
        test_split_handshake();
        test_backpressure();
        test_reset_mid_op();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
